// File: rtl/sha256_arbiter.sv
// sha256_arbiter: shares one sha256 core between NUM_REQ requesters, one whole message at a time,
// with round-robin selection of the next message owner.
module sha256_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_first_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ*512-1:0] req_block_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [255:0]           rsp_digest_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic                   sha_init_o,
  output logic                   sha_next_o,
  output logic [511:0]           sha_block_o,
  input  logic                   sha_ready_i,
  input  logic                   sha_digest_valid_i,
  input  logic [255:0]           sha_digest_i
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, RESP} state_e;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, last_grant_q, last_grant_d, win, cand;
  logic             last_flag_q, last_flag_d, first_flag_q, first_flag_d, guard_q, found;
  logic [511:0]     block_q, block_d;
  logic [255:0]     digest_q, digest_d;
  logic [511:0]     blks [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_blk
    assign blks[g] = req_block_i[g*512 +: 512];
  end
  // first eligible requester strictly after the previous winner, wrapping
  always_comb begin
    win = '0;
    cand = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!found && req_valid_i[cand] && req_first_i[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_grant_d = last_grant_q;
    last_flag_d = last_flag_q;
    first_flag_d = first_flag_q;
    block_d = block_q;
    digest_d = digest_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    sha_init_o = 1'b0;
    sha_next_o = 1'b0;
    case (state_q)
      IDLE: if (rst_ni && found && sha_ready_i) begin
        req_ready_o[win] = 1'b1;
        owner_d = win;
        block_d = blks[win];
        last_flag_d = req_last_i[win];
        first_flag_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        sha_init_o = first_flag_q;
        sha_next_o = !first_flag_q;
        state_d = WAIT;
      end
      // the core only drops ready one cycle after the strobe, hence the guard cycle
      WAIT: if (!guard_q && sha_ready_i && sha_digest_valid_i) begin
        state_d = last_flag_q ? RESP : HOLD;
        digest_d = last_flag_q ? sha_digest_i : digest_q;
      end
      HOLD: if (req_valid_i[owner_q]) begin
        req_ready_o[owner_q] = 1'b1;
        block_d = blks[owner_q];
        last_flag_d = req_last_i[owner_q];
        first_flag_d = req_first_i[owner_q];
        state_d = ISSUE;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        last_grant_d = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      last_flag_q <= 1'b0;
      first_flag_q <= 1'b0;
      guard_q <= 1'b0;
      block_q <= '0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_grant_q <= last_grant_d;
      last_flag_q <= last_flag_d;
      first_flag_q <= first_flag_d;
      guard_q <= (state_q == ISSUE);
      block_q <= block_d;
      digest_q <= digest_d;
    end
  end
  assign busy_o = (state_q != IDLE);
  assign owner_o = owner_q;
  assign sha_block_o = block_q;
  assign rsp_digest_o = digest_q;
endmodule
